// File: rtl/key_pkg.sv
// key_pkg
// Shared definitions for the key debouncer slice: the 2-bit FSM state
// encoding and the default timing constants (50 MHz clock assumed).
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;     // 1 ms
    localparam int unsigned REPEAT_DELAY_DEF    = 25000000;  // 500 ms
    localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;   // 100 ms

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   CLK_i  - clock
//   RSTN_i - asynchronous active-low reset; both flops load RST_VAL
//   D_i    - asynchronous input level
//   Q_o    - synchronized level (2 cycles of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK_i,
    input  logic RSTN_i,
    input  logic D_i,
    output logic Q_o
);

    logic meta;
    logic sync;

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
        end else begin
            meta <= D_i;
            sync <= meta;
        end
    end

    assign Q_o = sync;

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
// Push-button debouncer with press/release pulses and optional auto-repeat.
// The raw key is synchronized, normalised to 1 = pressed, and a change is
// accepted only after it stays stable for DEBOUNCE_CYCLES synced cycles.
// Define KEY_DEBOUNCER_REPEAT_EN to build the auto-repeat counter; without it
// REPEAT_o is tied low and REPEAT_DELAY/REPEAT_PERIOD have no effect.
// Ports:
//   CLK_i       - clock, rising edge
//   RSTN_i      - asynchronous active-low reset
//   KEY_i       - raw push-button level
//   KEY_STATE_o - debounced level, 1 = pressed
//   PRESS_o     - one-cycle pulse on an accepted press
//   RELEASE_o   - one-cycle pulse on an accepted release
//   REPEAT_o    - one-cycle auto-repeat pulse while held
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned KEY_ACTIVE_LOW  = 1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic CLK_i,
    input  logic RSTN_i,
    input  logic KEY_i,
    output logic KEY_STATE_o,
    output logic PRESS_o,
    output logic RELEASE_o,
    output logic REPEAT_o
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Synchronizer resets to the released raw level so reset never looks
    // like a press.
    localparam logic               SYNC_RST = (KEY_ACTIVE_LOW != 0);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_debouncer: cycle parameters must be >= 1");
    end

    logic             key_sync;
    logic             key_lvl;
    key_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt;
    logic             press_q, rel_q, key_state_q;

    sync_2ff #(.RST_VAL(SYNC_RST)) u_sync (
        .CLK_i  (CLK_i),
        .RSTN_i (RSTN_i),
        .D_i    (KEY_i),
        .Q_o    (key_sync)
    );

    assign key_lvl = (KEY_ACTIVE_LOW != 0) ? ~key_sync : key_sync;

    // Counter defaults to 0, so it only holds a value while a wait state
    // keeps counting; it stops at CNT_LAST because that leaves the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_lvl) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!key_lvl) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_lvl) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (key_lvl) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pulses and the level are registered off the next state so they appear
    // together in the cycle after the accepting transition.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            state       <= IDLE;
            cnt         <= '0;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
            key_state_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            press_q     <= press_nxt;
            rel_q       <= rel_nxt;
            key_state_q <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
        end
    end

    assign KEY_STATE_o = key_state_q;
    assign PRESS_o     = press_q;
    assign RELEASE_o   = rel_q;

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_last;
    logic             rep_armed;   // first delay done, now on the period
    logic             rep_q;

    assign rep_last = rep_armed ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);

    // Counts HELD cycles only: frozen in RELEASE_WAIT so a bounce during the
    // hold does not restart the cadence; cleared in IDLE. Repeat can only
    // fire from HELD, so it never coincides with PRESS_o/RELEASE_o.
    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            case (state)
                IDLE: begin
                    rep_cnt   <= '0;
                    rep_armed <= 1'b0;
                end
                HELD: begin
                    if (rep_cnt == rep_last) begin
                        rep_cnt   <= '0;
                        rep_armed <= 1'b1;
                        rep_q     <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign REPEAT_o = rep_q;
`else
    assign REPEAT_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
// Instance a: DEBOUNCE_CYCLES=4, active-low key. Instance b: DEBOUNCE_CYCLES=1,
// active-high key, driven with the complement of instance a's key except in
// the random phase. Both are compared every cycle against a run-length
// reference model; directed latency/count checks cover the scenarios.
module tb_key_debouncer;

    localparam int DB   = 4;
    localparam int RDLY = 20;
    localparam int RPER = 8;

    typedef struct {
        logic syn1, syn2;   // raw key delayed by 1 and 2 edges
        logic a;            // accepted level, 1 = pressed
        int   run;          // consecutive synced samples differing from a
        int   hcnt;         // held cycles since last press / repeat
        int   tgt;
        logic press, rel, rep;
    } mdl_t;

    logic CLK_i = 1'b0;
    logic RSTN_i;
    logic KEY_i, key1;
    logic st0, pr0, rl0, rp0;
    logic st1, pr1, rl1, rp1;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int last_press0 = -1000, last_press1 = -1000, last_rel0 = -1000;
    int press_cnt0 = 0, rel_cnt0 = 0, rep_cnt0 = 0;
    int rep_offs[$];
    mdl_t m0, m1;

    always #5 CLK_i = ~CLK_i;

    key_debouncer #(.DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(1),
                    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)) u_dut_a (
        .CLK_i(CLK_i), .RSTN_i(RSTN_i), .KEY_i(KEY_i),
        .KEY_STATE_o(st0), .PRESS_o(pr0), .RELEASE_o(rl0), .REPEAT_o(rp0));

    key_debouncer #(.DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(0),
                    .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)) u_dut_b (
        .CLK_i(CLK_i), .RSTN_i(RSTN_i), .KEY_i(key1),
        .KEY_STATE_o(st1), .PRESS_o(pr1), .RELEASE_o(rl1), .REPEAT_o(rp1));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic mdl_t mreset(input bit al);
        mdl_t m;
        m.syn1 = al; m.syn2 = al; m.a = 1'b0;
        m.run = 0; m.hcnt = 0; m.tgt = RDLY;
        m.press = 1'b0; m.rel = 1'b0; m.rep = 1'b0;
        return m;
    endfunction

    // A level change is accepted once d+1 consecutive synced samples disagree
    // with the accepted level (d stable cycles after the first one is seen).
    function automatic mdl_t step(input mdl_t m, input logic raw, input int d, input bit al);
        mdl_t n = m;
        logic lvl = al ? ~m.syn2 : m.syn2;
        bit held = m.a && (m.run == 0);
        n.press = 1'b0; n.rel = 1'b0; n.rep = 1'b0;
        if (lvl != m.a) begin
            n.run = m.run + 1;
            if (n.run == d + 1) begin
                n.a = lvl; n.run = 0;
                if (lvl) n.press = 1'b1; else n.rel = 1'b1;
            end
        end else begin
            n.run = 0;
        end
`ifdef KEY_DEBOUNCER_REPEAT_EN
        if (held) begin
            n.hcnt = m.hcnt + 1;
            if (n.hcnt == m.tgt) begin
                n.rep = 1'b1; n.hcnt = 0; n.tgt = RPER;
            end
        end
`endif
        if (n.rel) begin n.hcnt = 0; n.tgt = RDLY; end
        n.syn2 = m.syn1;
        n.syn1 = raw;
        return n;
    endfunction

    task automatic tick();
        @(posedge CLK_i);
        cyc++;
        if (!RSTN_i) begin
            m0 = mreset(1'b1); m1 = mreset(1'b0);
        end else begin
            m0 = step(m0, KEY_i, DB, 1'b1);
            m1 = step(m1, key1, 1, 1'b0);
        end
        #1;
        chk("a.state", st0, m0.a);
        chk("a.press", pr0, m0.press);
        chk("a.release", rl0, m0.rel);
        chk("a.repeat", rp0, m0.rep);
        chk("a.onehot", int'(pr0) + int'(rl0) + int'(rp0) <= 1, 1);
        chk("b.state", st1, m1.a);
        chk("b.press", pr1, m1.press);
        chk("b.release", rl1, m1.rel);
        chk("b.repeat", rp1, m1.rep);
        if (pr0) begin last_press0 = cyc; press_cnt0++; end
        if (rl0) begin last_rel0 = cyc; rel_cnt0++; end
        if (rp0) begin rep_cnt0++; rep_offs.push_back(cyc - last_press0); end
        if (pr1) last_press1 = cyc;
    endtask

    task automatic set_key(input logic v);
        KEY_i = v;
        key1  = ~v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".state"}, int'(st0) + int'(st1), 0);
        chk({tag, ".pulses"}, int'(pr0) + int'(rl0) + int'(rp0) + int'(pr1) + int'(rl1) + int'(rp1), 0);
    endtask

    initial begin
        int t0, p0, r0;
        RSTN_i = 1'b0;
        set_key(1'b1);
        m0 = mreset(1'b1); m1 = mreset(1'b0);
        #2;
        chk_zero("reset");
        repeat (3) tick();
        RSTN_i = 1'b1;
        repeat (4) tick();

        // clean press
        set_key(1'b0); t0 = cyc; p0 = press_cnt0; r0 = rel_cnt0;
        repeat (30) tick();
        chk("press_latency", last_press0 - t0, 7);
        chk("press_latency_db1", last_press1 - t0, 4);
        chk("press_count", press_cnt0 - p0, 1);
        chk("press_no_release", rel_cnt0 - r0, 0);
        chk("press_level", st0, 1);

        // clean release
        set_key(1'b1); t0 = cyc; r0 = rel_cnt0;
        repeat (15) tick();
        chk("release_latency", last_rel0 - t0, 7);
        chk("release_count", rel_cnt0 - r0, 1);
        chk("release_level", st0, 0);

        // bounce: toggle every 2 cycles for 20 cycles, then settle pressed
        p0 = press_cnt0;
        for (int i = 0; i < 10; i++) begin
            set_key((i % 2) == 0 ? 1'b0 : 1'b1);
            repeat (2) tick();
        end
        chk("bounce_quiet", press_cnt0 - p0, 0);
        set_key(1'b0);
        repeat (15) tick();
        chk("bounce_settle", press_cnt0 - p0, 1);
        set_key(1'b1);
        repeat (15) tick();

        // 3-cycle press glitch
        p0 = press_cnt0;
        set_key(1'b0); repeat (3) tick();
        set_key(1'b1); repeat (10) tick();
        chk("glitch_no_press", press_cnt0 - p0, 0);
        chk("glitch_level", st0, 0);

        // release glitch while held
        set_key(1'b0); repeat (12) tick();
        r0 = rel_cnt0;
        set_key(1'b1); repeat (3) tick();
        set_key(1'b0); repeat (10) tick();
        chk("rglitch_no_release", rel_cnt0 - r0, 0);
        chk("rglitch_level", st0, 1);
        set_key(1'b1); repeat (12) tick();

        // long hold: auto-repeat cadence
        rep_offs.delete(); r0 = rep_cnt0;
        set_key(1'b0);
        repeat (60) tick();
`ifdef KEY_DEBOUNCER_REPEAT_EN
        chk("repeat_count", rep_cnt0 - r0, 5);
        for (int i = 0; i < 5; i++)
            chk("repeat_offset", (i < rep_offs.size()) ? rep_offs[i] : -1, RDLY + i * RPER);
`else
        chk("repeat_count", rep_cnt0 - r0, 0);
`endif
        set_key(1'b1); repeat (12) tick();

        // reset mid-hold, then release reset with the key still pressed
        set_key(1'b0); repeat (12) tick();
        r0 = rel_cnt0;
        RSTN_i = 1'b0;
        #1;
        m0 = mreset(1'b1); m1 = mreset(1'b0);
        chk_zero("midhold_reset");
        repeat (3) tick();
        RSTN_i = 1'b1; t0 = cyc;
        repeat (12) tick();
        chk("reset_press_latency", last_press0 - t0, 7);
        chk("reset_no_release", rel_cnt0 - r0, 0);
        set_key(1'b1); repeat (12) tick();

        // random segments, independent keys, occasional reset
        for (int s = 0; s < 300; s++) begin
            KEY_i = 1'($urandom_range(0, 1));
            key1  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                RSTN_i = 1'b0;
                #1;
                m0 = mreset(1'b1); m1 = mreset(1'b0);
                chk_zero("rand_reset");
                tick();
                RSTN_i = 1'b1;
            end
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
